wb2lb_bridge: RTL and testbench
===============================

# wb2lb_bridge

Wishbone classic slave to simple local-bus bridge: terminates the Wishbone cycles driven by the test-bench Wishbone master and re-issues them as single-pulse write/read strobes on the local register bus that register-map blocks consume. It sits directly downstream of the Wishbone master. It holds one transaction in flight, waits for the local-bus completion, and returns a one-cycle `wb_ack_o`. A timeout guards against a non-responding register block.

## Interface
- `ADDR_W`, 16, address width (byte address, passed unchanged)
- `DATA_W`, 32, data width, multiple of 8
- `STRB_W`, `DATA_W/8`, byte-select width
- `TIMEOUT`, 255, max cycles waiting for local-bus completion; 0 disables timeout
- `TIMEOUT_DATA`, `32'hDEAD_BEEF` (truncated/zero-extended to `DATA_W`), read data returned on timeout

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `wb_adr_i`  in  ADDR_W  Wishbone address
- `wb_dat_i`  in  DATA_W  Wishbone write data
- `wb_we_i`  in  1  1 = write, 0 = read
- `wb_stb_i`  in  1  strobe
- `wb_cyc_i`  in  1  cycle valid
- `wb_sel_i`  in  STRB_W  byte selects
- `wb_dat_o`  out  DATA_W  read data, valid while `wb_ack_o` high
- `wb_ack_o`  out  1  one-cycle acknowledge
- `lb_waddr`  out  ADDR_W  local write address
- `lb_wdata`  out  DATA_W  local write data
- `lb_wstrb`  out  STRB_W  local byte strobes
- `lb_wen`  out  1  one-cycle write pulse
- `lb_wready`  in  1  write accepted; may coincide with `lb_wen`
- `lb_raddr`  out  ADDR_W  local read address
- `lb_ren`  out  1  one-cycle read pulse
- `lb_rdata`  in  DATA_W  read data, sampled when `lb_rvalid` is high
- `lb_rvalid`  in  1  read data valid; may coincide with `lb_ren`
- `timeout_o`  out  1  one-cycle pulse when a transaction is acked due to timeout

## Operation
- States: IDLE, WRITE, READ, ACK.
- IDLE: on `wb_cyc_i & wb_stb_i`, latch adr/dat/sel/we.
  - If `we`, go to WRITE and drive `lb_wen` = 1 for the first WRITE cycle only.
  - Otherwise go to READ and drive `lb_ren` = 1 for the first READ cycle only.
- WRITE: on `lb_wready`, go to ACK.
- READ: on `lb_rvalid`, capture `lb_rdata` into `wb_dat_o` and go to ACK.
- Completion sampling in WRITE/READ includes the pulse cycle itself.
- ACK: `wb_ack_o` = 1 for exactly one cycle, then go to IDLE.
  - ACK→IDLE is unconditional; the next request is evaluated in IDLE on the following edge, so back-to-back requests get no ack overlap.
- Address/data/strobe outputs hold their latched values from request latch until the next request; they are don't-care to consumers outside the pulse.
- Write ack: `wb_dat_o` is driven to 0.
- Abort: `wb_cyc_i` low in WRITE or READ → IDLE with no ack. An issued local strobe is not retracted, and a late `lb_wready`/`lb_rvalid` is ignored.
- Timeout: counter clears on entry to WRITE/READ and increments each cycle there.
  - When count == `TIMEOUT` (and `TIMEOUT` != 0) with no completion, go to ACK and pulse `timeout_o` with `wb_ack_o`.
  - On a read timeout, `wb_dat_o` = `TIMEOUT_DATA`.
  - If completion and timeout fall in the same cycle, completion wins and there is no `timeout_o`.
- Counter width: `$clog2(TIMEOUT+1)`, saturating; it never wraps.

## Timing
- Reset (`reset` = 0 at an edge) forces IDLE. All outputs go to 0: `wb_ack_o`, `wb_dat_o`, `lb_wen`, `lb_ren`, `timeout_o`, all `lb_*` address/data/strobe outputs, and the counter.
- Reset mid-transaction drops it with no ack.
- All outputs are registered; no combinational path from inputs to outputs.
- Request sampled at edge N. Then:
  - `lb_wen`/`lb_ren` is high in cycle N..N+1.
  - Completion seen at edge N+1 gives `wb_ack_o` high in cycle N+1..N+2.
  - Minimum latency is therefore 2 edges from request to ack; each cycle of local-bus wait adds 1.
- Timeout ack: `wb_ack_o` rises one cycle after the edge where count == `TIMEOUT`, i.e. `TIMEOUT`+2 edges after the request.

## Structure
- Package `wb2lb_pkg`: state enum `wb2lb_state_t` {IDLE, WRITE, READ, ACK}, default `TIMEOUT_DATA` localparam.
- Sub-module `wb2lb_tmo`: clear/enable saturating counter with `expired` output, parameterised by `TIMEOUT`. Everything else stays in `wb2lb_bridge`.

## Test plan
- Write 0x0010 ← 0xA5A5_1234, sel 0xF, `lb_wready` tied 1 → one `lb_wen` pulse with addr 0x0010, data 0xA5A5_1234, strb 0xF; `wb_ack_o` one cycle, 2 edges after request.
- Read 0x0020, `lb_rvalid` 3 cycles after `lb_ren` with `lb_rdata` 0xCAFE_F00D → BFM read returns 0xCAFE_F00D; exactly one `lb_ren` pulse.
- Partial write sel 0x3 → `lb_wstrb` 0x3; back-to-back write then read → no overlapping acks, each one cycle.
- `TIMEOUT` = 8, `lb_rvalid` never asserted → ack 10 edges after request, data 0xDEAD_BEEF, `timeout_o` pulses once; the next read completes normally.
- Completion on the same cycle count reaches `TIMEOUT` → real data returned, `timeout_o` stays 0.
- `wb_cyc_i` dropped while in READ, or `reset` low mid-write → no ack, state IDLE, outputs 0 after reset; a late `lb_rvalid` is ignored.

Source files
------------

// File: rtl/wb2lb_pkg.sv
// Shared types and defaults for the Wishbone-to-local-bus bridge.
package wb2lb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } wb2lb_state_t;

    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb2lb_tmo.sv
// Clear/enable saturating wait counter; expired flags count == TIMEOUT (never when TIMEOUT is 0).
module wb2lb_tmo #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holding at LIMIT keeps the counter from wrapping back under it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block with no reset term in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/wb2lb_bridge.sv
// Wishbone classic slave that replays each cycle as a single local-bus strobe and returns a one-cycle ack.
module wb2lb_bridge
    import wb2lb_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       STRB_W       = DATA_W / 8,
    parameter int unsigned       TIMEOUT      = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic [STRB_W-1:0] wb_sel_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid,
    output logic              timeout_o
);

    wb2lb_state_t      state_q, state_d;
    logic              wb_ack_q, wb_ack_d;
    logic [DATA_W-1:0] wb_dat_q, wb_dat_d;
    logic [ADDR_W-1:0] lb_waddr_q, lb_waddr_d;
    logic [DATA_W-1:0] lb_wdata_q, lb_wdata_d;
    logic [STRB_W-1:0] lb_wstrb_q, lb_wstrb_d;
    logic              lb_wen_q, lb_wen_d;
    logic [ADDR_W-1:0] lb_raddr_q, lb_raddr_d;
    logic              lb_ren_q, lb_ren_d;
    logic              timeout_q, timeout_d;
    logic              busy;
    logic              tmo_expired;

    assign busy = (state_q == WRITE) || (state_q == READ);

    wb2lb_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr     (!busy),
        .en      (busy),
        .expired (tmo_expired)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        wb_ack_d   = 1'b0;
        wb_dat_d   = wb_dat_q;
        lb_waddr_d = lb_waddr_q;
        lb_wdata_d = lb_wdata_q;
        lb_wstrb_d = lb_wstrb_q;
        lb_wen_d   = 1'b0;
        lb_raddr_d = lb_raddr_q;
        lb_ren_d   = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    lb_waddr_d = wb_adr_i;
                    lb_raddr_d = wb_adr_i;
                    lb_wdata_d = wb_dat_i;
                    lb_wstrb_d = wb_sel_i;
                    if (wb_we_i) begin
                        state_d  = WRITE;
                        lb_wen_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        lb_ren_d = 1'b1;
                    end
                end
            end
            // A dropped cycle beats a completion in the same cycle: the master is no longer listening.
            WRITE: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (lb_wready || tmo_expired) begin
                    state_d   = ACK;
                    wb_ack_d  = 1'b1;
                    wb_dat_d  = '0;
                    timeout_d = !lb_wready;
                end
            end
            READ: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (lb_rvalid) begin
                    state_d  = ACK;
                    wb_ack_d = 1'b1;
                    wb_dat_d = lb_rdata;
                end else if (tmo_expired) begin
                    state_d   = ACK;
                    wb_ack_d  = 1'b1;
                    wb_dat_d  = TIMEOUT_DATA;
                    timeout_d = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wb_ack_q   <= 1'b0;
            wb_dat_q   <= '0;
            lb_waddr_q <= '0;
            lb_wdata_q <= '0;
            lb_wstrb_q <= '0;
            lb_wen_q   <= 1'b0;
            lb_raddr_q <= '0;
            lb_ren_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_ack_q   <= wb_ack_d;
            wb_dat_q   <= wb_dat_d;
            lb_waddr_q <= lb_waddr_d;
            lb_wdata_q <= lb_wdata_d;
            lb_wstrb_q <= lb_wstrb_d;
            lb_wen_q   <= lb_wen_d;
            lb_raddr_q <= lb_raddr_d;
            lb_ren_q   <= lb_ren_d;
            timeout_q  <= timeout_d;
        end
    end

    assign wb_ack_o  = wb_ack_q;
    assign wb_dat_o  = wb_dat_q;
    assign lb_waddr  = lb_waddr_q;
    assign lb_wdata  = lb_wdata_q;
    assign lb_wstrb  = lb_wstrb_q;
    assign lb_wen    = lb_wen_q;
    assign lb_raddr  = lb_raddr_q;
    assign lb_ren    = lb_ren_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb2lb_bridge.sv
// Directed bench for wb2lb_bridge with TIMEOUT = 8 and a delay-programmable local-bus responder.
module tb_wb2lb_bridge;

    localparam int TMO = 8;

    logic        clk;
    logic        reset;
    logic [15:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [15:0] lb_waddr;
    logic [31:0] lb_wdata;
    logic [3:0]  lb_wstrb;
    logic        lb_wen;
    logic        lb_wready;
    logic [15:0] lb_raddr;
    logic        lb_ren;
    logic [31:0] lb_rdata;
    logic        lb_rvalid;
    logic        timeout_o;

    wb2lb_bridge #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_we_i   (wb_we_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .lb_waddr  (lb_waddr),
        .lb_wdata  (lb_wdata),
        .lb_wstrb  (lb_wstrb),
        .lb_wen    (lb_wen),
        .lb_wready (lb_wready),
        .lb_raddr  (lb_raddr),
        .lb_ren    (lb_ren),
        .lb_rdata  (lb_rdata),
        .lb_rvalid (lb_rvalid),
        .timeout_o (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Local-bus read responder: lb_rvalid rises rd_delay cycles after the lb_ren pulse, never when rd_delay < 0.
    int          rd_delay = 0;
    logic [31:0] rd_value = 32'h0;
    bit          pend;
    int          wcnt;

    initial begin
        lb_rvalid = 1'b0;
        lb_rdata  = 32'h0;
        pend      = 1'b0;
        wcnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (lb_rvalid) pend = 1'b0;
            if (lb_ren) begin
                pend = 1'b1;
                wcnt = rd_delay;
            end else if (pend && wcnt > 0) begin
                wcnt--;
            end
            lb_rvalid = pend && (rd_delay >= 0) && (wcnt == 0);
            lb_rdata  = lb_rvalid ? rd_value : 32'h0;
        end
    end

    // Pulse monitor sampled mid-cycle.
    int          n_wen = 0, n_ren = 0, n_ack = 0, n_tmo = 0, ack_double = 0;
    bit          prev_ack = 1'b0;
    logic [15:0] cap_waddr = '0, cap_raddr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (lb_wen === 1'b1) begin
                n_wen++;
                cap_waddr = lb_waddr;
                cap_wdata = lb_wdata;
                cap_wstrb = lb_wstrb;
            end
            if (lb_ren === 1'b1) begin
                n_ren++;
                cap_raddr = lb_raddr;
            end
            if (timeout_o === 1'b1) n_tmo++;
            if (wb_ack_o === 1'b1) begin
                n_ack++;
                if (prev_ack) ack_double++;
            end
            prev_ack = (wb_ack_o === 1'b1);
        end
    end

    // One Wishbone classic transfer; lat counts edges from the request edge up to and including the ack edge.
    task automatic wb_xfer(input logic [15:0] adr, input logic [31:0] dat, input logic we,
                           input logic [3:0] sel, input bit gap,
                           output logic [31:0] rdata, output int lat, output logic tmo);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        lat   = 0;
        rdata = 32'h0;
        tmo   = 1'b0;
        do begin
            step();
            lat++;
        end while (!wb_ack_o && lat < 40);
        if (wb_ack_o) begin
            rdata = wb_dat_o;
            tmo   = timeout_o;
        end else begin
            lat = -1;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        if (gap) step();
    endtask

    logic [31:0] rd;
    int          lat;
    logic        tmo;
    int          ack0;
    int          tmo0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        wb_adr_i  = '0;
        wb_dat_i  = '0;
        wb_we_i   = 1'b0;
        wb_stb_i  = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_sel_i  = '0;
        lb_wready = 1'b1;

        repeat (2) step();
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_wen", lb_wen, 0);
        check("rst_ren", lb_ren, 0);
        check("rst_tmo", timeout_o, 0);
        check("rst_waddr", lb_waddr, 0);
        reset = 1'b1;
        step();

        // Single write, ready tied high.
        wb_xfer(16'h0010, 32'hA5A5_1234, 1'b1, 4'hF, 1'b1, rd, lat, tmo);
        check("wr1_lat", lat, 2);
        check("wr1_tmo", tmo, 0);
        check("wr1_wen_cnt", n_wen, 1);
        check("wr1_waddr", cap_waddr, 32'h0010);
        check("wr1_wdata", cap_wdata, 32'hA5A5_1234);
        check("wr1_wstrb", cap_wstrb, 4'hF);
        check("wr1_ack_cnt", n_ack, 1);
        check("wr1_ren_cnt", n_ren, 0);

        // Read with three cycles of local-bus wait.
        rd_delay = 3;
        rd_value = 32'hCAFE_F00D;
        wb_xfer(16'h0020, 32'h0, 1'b0, 4'hF, 1'b1, rd, lat, tmo);
        check("rd1_lat", lat, 5);
        check("rd1_data", rd, 32'hCAFE_F00D);
        check("rd1_tmo", tmo, 0);
        check("rd1_ren_cnt", n_ren, 1);
        check("rd1_raddr", cap_raddr, 32'h0020);

        // Partial write; write ack returns zero data.
        wb_xfer(16'h0030, 32'h0000_BEEF, 1'b1, 4'h3, 1'b1, rd, lat, tmo);
        check("wr2_lat", lat, 2);
        check("wr2_wstrb", cap_wstrb, 4'h3);
        check("wr2_ackdata", rd, 32'h0);

        // Back-to-back write then read: the request raised during ACK waits for IDLE.
        wb_xfer(16'h0034, 32'h5555_AAAA, 1'b1, 4'hF, 1'b0, rd, lat, tmo);
        check("b2b_wr_lat", lat, 2);
        rd_delay = 0;
        rd_value = 32'h0BAD_CAFE;
        wb_xfer(16'h0038, 32'h0, 1'b0, 4'hF, 1'b1, rd, lat, tmo);
        check("b2b_rd_lat", lat, 3);
        check("b2b_rd_data", rd, 32'h0BAD_CAFE);
        check("b2b_raddr", cap_raddr, 32'h0038);
        check("b2b_ack_cnt", n_ack, 5);

        // Read timeout.
        rd_delay = -1;
        wb_xfer(16'h0044, 32'h0, 1'b0, 4'hF, 1'b1, rd, lat, tmo);
        check("tmo_rd_lat", lat, TMO + 2);
        check("tmo_rd_data", rd, 32'hDEAD_BEEF);
        check("tmo_rd_flag", tmo, 1);
        check("tmo_rd_cnt", n_tmo, 1);

        rd_delay = 2;
        rd_value = 32'h1357_9BDF;
        wb_xfer(16'h0048, 32'h0, 1'b0, 4'hF, 1'b1, rd, lat, tmo);
        check("post_tmo_lat", lat, 4);
        check("post_tmo_data", rd, 32'h1357_9BDF);
        check("post_tmo_flag", tmo, 0);

        // Completion on the very cycle the count reaches TIMEOUT.
        rd_delay = TMO;
        rd_value = 32'h2468_ACE0;
        wb_xfer(16'h004C, 32'h0, 1'b0, 4'hF, 1'b1, rd, lat, tmo);
        check("edge_lat", lat, TMO + 2);
        check("edge_data", rd, 32'h2468_ACE0);
        check("edge_flag", tmo, 0);
        check("edge_tmo_cnt", n_tmo, 1);

        // Write timeout.
        lb_wready = 1'b0;
        wb_xfer(16'h0054, 32'h9999_0000, 1'b1, 4'hF, 1'b1, rd, lat, tmo);
        check("tmo_wr_lat", lat, TMO + 2);
        check("tmo_wr_flag", tmo, 1);
        check("tmo_wr_data", rd, 32'h0);
        lb_wready = 1'b1;

        // Abort a read; its late lb_rvalid must be ignored.
        rd_delay = 4;
        rd_value = 32'h7777_7777;
        ack0 = n_ack;
        tmo0 = n_tmo;
        wb_adr_i = 16'h0050;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();
        check("abort_ren", lb_ren, 1);
        step();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (TMO + 4) step();
        check("abort_no_ack", n_ack - ack0, 0);
        check("abort_no_tmo", n_tmo - tmo0, 0);
        rd_delay = 1;
        rd_value = 32'h1234_5678;
        wb_xfer(16'h0058, 32'h0, 1'b0, 4'hF, 1'b1, rd, lat, tmo);
        check("post_abort_lat", lat, 3);
        check("post_abort_data", rd, 32'h1234_5678);

        // Reset in the middle of a stalled write.
        lb_wready = 1'b0;
        ack0 = n_ack;
        wb_adr_i = 16'h0060;
        wb_dat_i = 32'h1111_2222;
        wb_we_i  = 1'b1;
        wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();
        check("mid_wen", lb_wen, 1);
        step();
        reset = 1'b0;
        step();
        check("mid_rst_ack", wb_ack_o, 0);
        check("mid_rst_dat", wb_dat_o, 0);
        check("mid_rst_waddr", lb_waddr, 0);
        check("mid_rst_wdata", lb_wdata, 0);
        check("mid_rst_wstrb", lb_wstrb, 0);
        check("mid_rst_raddr", lb_raddr, 0);
        check("mid_rst_wen", lb_wen, 0);
        check("mid_rst_ren", lb_ren, 0);
        check("mid_rst_tmo", timeout_o, 0);
        reset    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        lb_wready = 1'b1;
        repeat (3) step();
        check("mid_rst_no_ack", n_ack - ack0, 0);
        wb_xfer(16'h0064, 32'h3333_4444, 1'b1, 4'hC, 1'b1, rd, lat, tmo);
        check("post_rst_lat", lat, 2);
        check("post_rst_wdata", cap_wdata, 32'h3333_4444);
        check("post_rst_wstrb", cap_wstrb, 4'hC);

        check("ack_never_double", ack_double, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
